// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract: one full-add cell stepped LSB first over WIDTH bits.
// Start/busy/done handshake; registered result and N/Z/C/V flags.
module serial_add_sequencer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             n_q, n_d;
    logic             z_q, z_d;
    logic             c_q, c_d;
    logic             v_q, v_d;

    logic             h1, g1, g2, bit_s, bit_c, last;
    logic [WIDTH-1:0] sh_next;

    // Full adder built from two half-add stages plus an OR for carry
    assign h1      = opa_q[0] ^ opb_q[0];
    assign g1      = opa_q[0] & opb_q[0];
    assign bit_s   = h1 ^ carry_q;
    assign g2      = h1 & carry_q;
    assign bit_c   = g1 | g2;
    assign sh_next = {bit_s, sh_q[WIDTH-1:1]};
    assign last    = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sh_d    = sh_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        n_d     = n_q;
        z_d     = z_q;
        c_d     = c_q;
        v_d     = v_q;
        unique case (state_q)
            RUN: begin
                opa_d   = {1'b0, opa_q[WIDTH-1:1]};
                opb_d   = {1'b0, opb_q[WIDTH-1:1]};
                sh_d    = sh_next;
                carry_d = bit_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last) begin
                    // carry_q here is the carry into the MSB
                    state_d = DONE;
                    res_d   = sh_next;
                    n_d     = sh_next[WIDTH-1];
                    z_d     = (sh_next == '0);
                    c_d     = bit_c;
                    v_d     = carry_q ^ bit_c;
                end
            end
            default: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    opa_d   = A;
                    opb_d   = sub ? ~B : B;
                    carry_d = sub;
                    cnt_d   = '0;
                    sh_d    = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sh_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sh_q    <= sh_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            n_q     <= n_d;
            z_q     <= z_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign result    = res_q;
    assign negative  = n_q;
    assign zero      = z_q;
    assign carry_out = c_q;
    assign overflow  = v_q;
endmodule
